// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Number of CHUNK-bit slices in a WIDTH-bit operand.
   function automatic int unsigned nch(input int unsigned width, input int unsigned chunk);
      return (chunk == 0) ? 0 : width / chunk;
   endfunction

   // Index width able to count n values, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Legal geometry: non-zero chunk that tiles the operand exactly.
   function automatic bit params_ok(input int unsigned width, input int unsigned chunk);
      return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module adder_chunk #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   // Single ripple of W bits plus the incoming carry.
   assign {cout, s} = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);

endmodule

// File: rtl/adder_seq_chunked.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB slice first.
module adder_seq_chunked
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset_a,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NCH = nch(WIDTH, CHUNK);
   localparam int unsigned CW  = cnt_w(NCH);
   localparam int unsigned IW  = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   // Reject geometries where CHUNK does not tile WIDTH.
   generate
      if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
         $error("adder_seq_chunked: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [IW-1:0]    base_c;
   logic [CHUNK-1:0] slice_a_c;
   logic [CHUNK-1:0] slice_b_c;
   logic [CHUNK-1:0] slice_s_c;
   logic             slice_co_c;

   // Select the operand slice addressed by the slice counter.
   always_comb begin
      base_c    = IW'(32'(cnt_q) * CHUNK);
      slice_a_c = a_q[base_c +: CHUNK];
      slice_b_c = b_q[base_c +: CHUNK];
   end

   adder_chunk #(
      .W (CHUNK)
   ) u_chunk (
      .a    (slice_a_c),
      .b    (slice_b_c),
      .cin  (carry_q),
      .s    (slice_s_c),
      .cout (slice_co_c)
   );

   // Next-state and datapath updates for the IDLE/RUN sequencer.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               // Subtraction is A + ~B + 1: invert B now, seed the carry with sub.
               a_d     = dataa;
               b_d     = sub ? ~datab : datab;
               carry_d = sub;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[base_c +: CHUNK] = slice_s_c;
            carry_d                = slice_co_c;
            cnt_d                  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cout_d  = slice_co_c;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (slice_s_c[CHUNK-1] != a_q[WIDTH-1]);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Self-checking bench for adder_seq_chunked across four geometries.
module tb_adder_seq_chunked;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   // Geometries: 0 = 16/4, 1 = 32/32, 2 = 24/8, 3 = 24/4
   localparam int unsigned NCH_T [4] = '{4, 1, 3, 6};
   localparam int unsigned WID_T [4] = '{16, 32, 24, 24};

   logic clk = 1'b0;
   logic reset_a;
   always #5 clk = ~clk;

   logic        st0, sb0, bz0, dn0, co0, ov0;
   logic [15:0] a0, b0, s0;
   logic        st1, sb1, bz1, dn1, co1, ov1;
   logic [31:0] a1, b1, s1;
   logic        st2, sb2, bz2, dn2, co2, ov2;
   logic [23:0] a2, b2, s2;
   logic        st3, sb3, bz3, dn3, co3, ov3;
   logic [23:0] a3, b3, s3;

   logic        x_busy [4];
   logic        x_done [4];
   logic        x_cout [4];
   logic        x_ovf  [4];
   logic [31:0] x_sum  [4];

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   adder_seq_chunked #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .reset_a(reset_a), .start(st0), .sub(sb0), .dataa(a0), .datab(b0),
      .busy(bz0), .done(dn0), .sum(s0), .cout(co0), .ovf(ov0));
   adder_seq_chunked #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .clk(clk), .reset_a(reset_a), .start(st1), .sub(sb1), .dataa(a1), .datab(b1),
      .busy(bz1), .done(dn1), .sum(s1), .cout(co1), .ovf(ov1));
   adder_seq_chunked #(.WIDTH(24), .CHUNK(8)) u_dut24w (
      .clk(clk), .reset_a(reset_a), .start(st2), .sub(sb2), .dataa(a2), .datab(b2),
      .busy(bz2), .done(dn2), .sum(s2), .cout(co2), .ovf(ov2));
   adder_seq_chunked #(.WIDTH(24), .CHUNK(4)) u_dut24n (
      .clk(clk), .reset_a(reset_a), .start(st3), .sub(sb3), .dataa(a3), .datab(b3),
      .busy(bz3), .done(dn3), .sum(s3), .cout(co3), .ovf(ov3));

   // Uniform view of the four instances' outputs.
   always_comb begin
      x_busy[0] = bz0; x_done[0] = dn0; x_cout[0] = co0; x_ovf[0] = ov0; x_sum[0] = 32'(s0);
      x_busy[1] = bz1; x_done[1] = dn1; x_cout[1] = co1; x_ovf[1] = ov1; x_sum[1] = s1;
      x_busy[2] = bz2; x_done[2] = dn2; x_cout[2] = co2; x_ovf[2] = ov2; x_sum[2] = 32'(s2);
      x_busy[3] = bz3; x_done[3] = dn3; x_cout[3] = co3; x_ovf[3] = ov3; x_sum[3] = 32'(s3);
   end

   // Reference: full-width two's-complement add/sub of width w.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input int unsigned w);
      logic [63:0] mask, av, bp, t;
      exp_t e;
      mask   = (64'd1 << w) - 64'd1;
      av     = {32'd0, a} & mask;
      bp     = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
      t      = av + bp + 64'(s);
      e.sum  = 32'(t & mask);
      e.cout = t[w];
      e.ovf  = (av[w-1] == bp[w-1]) && (t[w-1] != av[w-1]);
      return e;
   endfunction

   task automatic drive_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic st);
      case (sel)
         0:       begin st0 = st; sb0 = s; a0 = a[15:0]; b0 = b[15:0]; end
         1:       begin st1 = st; sb1 = s; a1 = a;       b1 = b;       end
         2:       begin st2 = st; sb2 = s; a2 = a[23:0]; b2 = b[23:0]; end
         default: begin st3 = st; sb3 = s; a3 = a[23:0]; b3 = b[23:0]; end
      endcase
   endtask

   // One-cycle start pulse; operands are scrambled afterwards to prove capture.
   task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
      drive_op(sel, a, b, s, 1'b1);
      @(posedge clk);
      #1;
      drive_op(sel, $urandom, $urandom, 1'($urandom), 1'b0);
   endtask

   // Counts rising edges until done is seen at a falling edge (bounded).
   task automatic wait_done(input int sel, output int n, output bit found);
      found = 1'b0;
      n     = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         found = x_done[sel];
      end
   endtask

   task automatic test_reset;
      reset_a = 1'b1;
      for (int s = 0; s < 4; s++) drive_op(s, 32'd0, 32'd0, 1'b0, 1'b0);
      #12;
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         checks++;
         if ({x_busy[s], x_done[s], x_cout[s], x_ovf[s]} !== 4'b0000 || x_sum[s] !== 32'd0) begin
            errors++;
            $display("FAIL reset_state dut%0d got busy=%b done=%b cout=%b ovf=%b sum=%h exp all zero",
                     s, x_busy[s], x_done[s], x_cout[s], x_ovf[s], x_sum[s]);
         end
      end
      reset_a = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int   n;
      bit   found;
      exp_t e, got;
      logic [31:0] held;
      exp_q.push_back('{sum: 32'd16, cout: 1'b0, ovf: 1'b0});
      start_op(0, 32'd10, 32'd6, 1'b0);
      @(negedge clk);
      checks++;
      if (x_busy[0] !== 1'b1 || x_done[0] !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy got busy=%b done=%b exp busy=1 done=0", x_busy[0], x_done[0]);
      end
      wait_done(0, n, found);
      checks++;
      if (!found || n != 4) begin
         errors++;
         $display("FAIL basic_latency got found=%0b edges=%0d exp found=1 edges=4", found, n);
      end
      checks++;
      if (x_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_at_done got %b exp 0", x_busy[0]);
      end
      e   = exp_q.pop_front();
      got = '{sum: x_sum[0], cout: x_cout[0], ovf: x_ovf[0]};
      held = x_sum[0];
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL basic_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                  got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (x_done[0] !== 1'b0 || x_sum[0] !== held) begin
         errors++;
         $display("FAIL basic_done_pulse got done=%b sum=%h exp done=0 sum=%h", x_done[0], x_sum[0], held);
      end
   endtask

   task automatic test_arith;
      logic [31:0] ta [14];
      logic [31:0] tb [14];
      logic        ts [14];
      exp_t        te [14];
      int          n;
      bit          found;
      exp_t        e, got;
      ta[0] = 32'd500;      tb[0] = 32'd256;    ts[0] = 1'b0; te[0] = '{32'd756,    1'b0, 1'b0};
      ta[1] = 32'hFFFF;     tb[1] = 32'h0001;   ts[1] = 1'b0; te[1] = '{32'h0000,   1'b1, 1'b0};
      ta[2] = 32'h7FFF;     tb[2] = 32'h0001;   ts[2] = 1'b0; te[2] = '{32'h8000,   1'b0, 1'b1};
      ta[3] = 32'd2;        tb[3] = 32'd4;      ts[3] = 1'b1; te[3] = '{32'hFFFE,   1'b0, 1'b0};
      ta[4] = 32'h8000;     tb[4] = 32'd1;      ts[4] = 1'b1; te[4] = '{32'h7FFF,   1'b1, 1'b1};
      ta[5] = 32'h1234;     tb[5] = 32'h1234;   ts[5] = 1'b1; te[5] = '{32'h0000,   1'b1, 1'b0};
      ta[6] = 32'h8000;     tb[6] = 32'h8000;   ts[6] = 1'b0; te[6] = '{32'h0000,   1'b1, 1'b1};
      ta[7] = 32'h0F0F;     tb[7] = 32'h00F1;   ts[7] = 1'b0; te[7] = '{32'h1000,   1'b0, 1'b0};
      for (int i = 8; i < 14; i++) begin
         ta[i] = 32'($urandom_range(0, 16'hFFFF));
         tb[i] = 32'($urandom_range(0, 16'hFFFF));
         ts[i] = 1'($urandom);
         te[i] = model(ta[i], tb[i], ts[i], 16);
      end
      for (int i = 0; i < 14; i++) begin
         exp_q.push_back(te[i]);
         start_op(0, ta[i], tb[i], ts[i]);
         wait_done(0, n, found);
         checks++;
         if (!found || n != 4) begin
            errors++;
            $display("FAIL arith_latency[%0d] got found=%0b edges=%0d exp found=1 edges=4", i, found, n);
         end
         e   = exp_q.pop_front();
         got = '{sum: x_sum[0], cout: x_cout[0], ovf: x_ovf[0]};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL arith_result[%0d] a=%h b=%h sub=%b got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                     i, ta[i], tb[i], ts[i], got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
         end
      end
   endtask

   task automatic test_busy_ignore;
      int   n, extra;
      bit   found;
      exp_t e, got;
      exp_q.push_back('{sum: 32'd123, cout: 1'b0, ovf: 1'b0});
      @(negedge clk);
      start_op(0, 32'd100, 32'd23, 1'b0);
      @(posedge clk);
      #1 drive_op(0, 32'hAAAA, 32'h5555, 1'b1, 1'b1);
      @(posedge clk);
      #1 drive_op(0, 32'd0, 32'd0, 1'b0, 1'b0);
      wait_done(0, n, found);
      checks++;
      if (!found || n != 2) begin
         errors++;
         $display("FAIL busy_ignore_latency got found=%0b edges=%0d exp found=1 edges=2", found, n);
      end
      e   = exp_q.pop_front();
      got = '{sum: x_sum[0], cout: x_cout[0], ovf: x_ovf[0]};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL busy_ignore_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                  got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (x_done[0] === 1'b1 || x_busy[0] === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL busy_ignore_extra_activity got %0d cycles exp 0", extra);
      end
   endtask

   task automatic test_back_to_back;
      int          last, dones;
      logic [31:0] a, b;
      logic        s;
      exp_t        e, got;
      last  = 0;
      dones = 0;
      @(negedge clk);
      a = $urandom; b = $urandom; s = 1'($urandom);
      exp_q.push_back(model(a, b, s, 16));
      drive_op(0, a, b, s, 1'b1);
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         if (n == 12) #1 st0 = 1'b0;
         @(negedge clk);
         if (x_done[0] === 1'b1) begin
            dones++;
            checks++;
            if (n - last != 5) begin
               errors++;
               $display("FAIL b2b_spacing got edge=%0d prev=%0d exp gap=5", n, last);
            end
            last = n;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_scoreboard got done with empty queue exp pending entry");
            end else begin
               e   = exp_q.pop_front();
               got = '{sum: x_sum[0], cout: x_cout[0], ovf: x_ovf[0]};
               if (got !== e) begin
                  errors++;
                  $display("FAIL b2b_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                           got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
               end
            end
            if (n < 12) begin
               a = $urandom; b = $urandom; s = 1'($urandom);
               exp_q.push_back(model(a, b, s, 16));
               drive_op(0, a, b, s, 1'b1);
            end
         end
      end
      checks++;
      if (dones != 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_count got dones=%0d pending=%0d exp dones=3 pending=0", dones, exp_q.size());
      end
   endtask

   task automatic test_reset_midrun;
      int   n, stray;
      bit   found;
      exp_t e, got;
      @(negedge clk);
      start_op(0, 32'h1111, 32'h2222, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 reset_a = 1'b1;
      #1;
      checks++;
      if ({x_busy[0], x_done[0], x_cout[0], x_ovf[0]} !== 4'b0000 || x_sum[0] !== 32'd0) begin
         errors++;
         $display("FAIL midrun_reset got busy=%b done=%b cout=%b ovf=%b sum=%h exp all zero",
                  x_busy[0], x_done[0], x_cout[0], x_ovf[0], x_sum[0]);
      end
      stray = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (x_done[0] === 1'b1) stray++;
      end
      reset_a = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (x_done[0] === 1'b1 || x_busy[0] === 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL midrun_no_done got %0d active cycles exp 0", stray);
      end
      exp_q.push_back('{sum: 32'h5555, cout: 1'b0, ovf: 1'b0});
      start_op(0, 32'h1234, 32'h4321, 1'b0);
      wait_done(0, n, found);
      checks++;
      if (!found || n != 4) begin
         errors++;
         $display("FAIL midrun_restart_latency got found=%0b edges=%0d exp found=1 edges=4", found, n);
      end
      e   = exp_q.pop_front();
      got = '{sum: x_sum[0], cout: x_cout[0], ovf: x_ovf[0]};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL midrun_restart_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                  got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end
   endtask

   task automatic test_configs;
      int          n;
      bit          found;
      exp_t        e, got;
      logic [31:0] a, b;
      logic        s;
      for (int sel = 1; sel < 4; sel++) begin
         for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
               if (sel == 1) begin
                  a = 32'hFFFF_FFFF; b = 32'd1; s = 1'b0;
                  exp_q.push_back('{sum: 32'd0, cout: 1'b1, ovf: 1'b0});
               end else begin
                  a = 32'h123456; b = 32'h654321; s = 1'b0;
                  exp_q.push_back('{sum: 32'h777777, cout: 1'b0, ovf: 1'b0});
               end
            end else begin
               a = $urandom; b = $urandom; s = 1'($urandom);
               exp_q.push_back(model(a, b, s, WID_T[sel]));
            end
            @(negedge clk);
            start_op(sel, a, b, s);
            wait_done(sel, n, found);
            checks++;
            if (!found || n != int'(NCH_T[sel])) begin
               errors++;
               $display("FAIL cfg%0d_latency[%0d] got found=%0b edges=%0d exp found=1 edges=%0d",
                        sel, k, found, n, NCH_T[sel]);
            end
            e   = exp_q.pop_front();
            got = '{sum: x_sum[sel], cout: x_cout[sel], ovf: x_ovf[sel]};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL cfg%0d_result[%0d] a=%h b=%h sub=%b got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                        sel, k, a, b, s, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
            end
         end
      end
   endtask

   // Hard stop if a bounded wait is somehow bypassed.
   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_arith();
      test_busy_ignore();
      test_back_to_back();
      test_reset_midrun();
      test_configs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
